rgb2gray_stage: RTL and testbench
=================================

// Module: rgb2gray_stage
// PURPOSE
//  Front stage of the edge-detector datapath. On a start pulse it streams every pixel of the
//  24-bit RGB frame buffer and converts each one to 8-bit luminance.
//  Each result is written to the same address in the 8-bit grayscale frame buffer.
//  Both buffers have a combinational read and a clocked write. The downstream blur and Sobel
//  stages consume the grayscale buffer once done pulses.
// PARAMETERS
//  NPIX  40000  pixels per frame (200x200); addresses 0..NPIX-1
//  AW    16     address width of both frame buffers
// PORTS
//  clk       in   1    single system clock, rising edge
//  rst_n     in   1    asynchronous active-low reset
//  start     in   1    one-cycle request to convert a frame; ignored while busy=1
//  src_addr  out  AW   read address into the RGB frame buffer
//  src_rd    in   24   RGB pixel at src_addr, valid in the same cycle: [23:16]=R [15:8]=G [7:0]=B
//  dst_we    out  1    write enable into the grayscale frame buffer
//  dst_addr  out  AW   write address into the grayscale frame buffer
//  dst_wd    out  8    luminance value to write
//  busy      out  1    high from the cycle after start until the last write has issued
//  done      out  1    one-cycle pulse when the frame is complete
// BEHAVIOUR
//  - Reset: one clock (clk), asynchronous active-low reset (rst_n).
//    Asserting rst_n=0 immediately forces: state=IDLE, src_addr=0, dst_we=0, dst_addr=0,
//    dst_wd=0, busy=0, done=0. Pipeline registers are cleared.
//  - FSM states: IDLE, RUN, DRAIN, DONE.
//    IDLE  -> RUN    on start=1; the read counter is loaded with 0
//    RUN   -> RUN    counter increments by 1 every cycle; src_addr = counter
//    RUN   -> DRAIN  in the cycle where counter==NPIX-1
//    DRAIN -> DONE   unconditionally; the last pixel's write is presented in this cycle
//    DONE  -> IDLE   unconditionally; done=1 for exactly this cycle
//  - busy = (state==RUN || state==DRAIN). In IDLE and DONE, src_addr is held at 0.
//  - Pipeline stage 1 (RUN cycles): register three values from src_rd:
//    pr=77*R, pg=150*G, pb=29*B (each 16 bits), plus addr_d=src_addr and v1=1.
//  - Pipeline stage 2: sum = pr+pg+pb+128 (16 bits).
//    dst_wd=sum[15:8], dst_addr=addr_d and dst_we=v1 are presented combinationally from the
//    stage-1 registers. The buffer commits the write on the following edge.
//  - Width rules: the weights total 256, so the worst case is 65280+128=65408 < 2^16.
//    No saturation is needed. Rounding is round-half-up via the +128 term.
//  - Latency: start sampled at edge E0, src_addr=0 during cycle 1, first dst_we during
//    cycle 2, last dst_we during cycle NPIX+1 (DRAIN), done during cycle NPIX+2.
//    Exactly NPIX writes occur per frame, each address written exactly once.
//  - Simultaneous events: start in RUN, DRAIN or DONE is ignored (no restart, no queueing).
//    start in the cycle after DONE (state IDLE) begins a new frame.
//  - Reset mid-frame: the conversion is abandoned with no further writes. The grayscale buffer
//    keeps whatever was already written. A subsequent start restarts from address 0.
//  - Counter never wraps: it stops at NPIX-1. src_addr never exceeds NPIX-1.
// STRUCTURE
//  - Shared package canny_pkg: NPIX, AW, luminance weights W_R=77 W_G=150 W_B=29,
//    LUMA_RND=128, and the FSM state encoding (2-bit: IDLE=0 RUN=1 DRAIN=2 DONE=3).
//    Later stages reuse NPIX, AW and the state-encoding style.
//  - One sub-module: rgb2gray_mul, which maps 24-bit RGB to the three registered 16-bit
//    products. The top level keeps the FSM, counter, adder and write port.
// TESTING
//  (bench pairs this block with behavioural RGB and grayscale frame-buffer models, NPIX=16
//   for the short runs)
//  1 Reset: rst_n=0 mid-RUN -> dst_we, busy and done fall to 0 in the same cycle, no edge
//    needed; no writes occur after that.
//  2 Pixel values: src 24'hFFFFFF -> 8'hFF; 24'h000000 -> 8'h00; 24'hFF0000 -> 8'd77;
//    24'h00FF00 -> 8'd149; 24'h0000FF -> 8'd29; 24'h808080 -> 8'd128.
//  3 Timing: start at edge E0 with NPIX=16
//    -> dst_we high in cycles 2..17, dst_addr = 0..15 in order, done high only in cycle 18,
//       busy high in cycles 1..17.
//  4 Start while busy: extra start pulses at cycles 5 and 17 and in the DONE cycle
//    -> still exactly 16 writes, a single done pulse, then the FSM returns to IDLE.
//  5 Back-to-back frames: start on the first cycle after done -> second frame output is
//    identical; full run with NPIX=40000 -> src_addr peaks at 39999 and 40000 writes occur.
//  6 Reset then restart: rst_n pulsed low at pixel 7, then start -> conversion resumes
//    from address 0 and every address 0..15 is rewritten.

Source files
------------

// File: rtl/canny_pkg.sv
// rtl/canny_pkg.sv - shared edge-detector constants, luminance weights and FSM encoding
package canny_pkg;

    localparam int NPIX = 40000;
    localparam int AW   = 16;

    localparam logic [15:0] W_R      = 16'd77;
    localparam logic [15:0] W_G      = 16'd150;
    localparam logic [15:0] W_B      = 16'd29;
    localparam logic [15:0] LUMA_RND = 16'd128;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic [15:0] pr;
        logic [15:0] pg;
        logic [15:0] pb;
    } luma_prod_t;

    // Weights sum to 256, so the 16-bit sum cannot overflow and the high byte is the rounded luma.
    function automatic logic [7:0] luma_round(input luma_prod_t p);
        logic [15:0] sum;
        sum = p.pr + p.pg + p.pb + LUMA_RND;
        return sum[15:8];
    endfunction

endpackage

// File: rtl/rgb2gray_stage_if.sv
// rtl/rgb2gray_stage_if.sv - RGB source and grayscale destination frame-buffer port bundle
interface rgb2gray_stage_if #(parameter int AW = canny_pkg::AW);

    logic [AW-1:0] src_addr;
    logic [23:0]   src_rd;
    logic          dst_we;
    logic [AW-1:0] dst_addr;
    logic [7:0]    dst_wd;

    modport master (output src_addr, input src_rd, output dst_we, output dst_addr, output dst_wd);
    modport slave  (input src_addr, output src_rd, input dst_we, input dst_addr, input dst_wd);

endinterface

// File: rtl/rgb2gray_mul.sv
// rtl/rgb2gray_mul.sv - registered weighted R/G/B products for the luminance adder
module rgb2gray_mul
    import canny_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [23:0] rgb,
    output luma_prod_t prod_q
);

    luma_prod_t prod_d;

    always_comb begin
        prod_d = prod_q;
        if (en) begin
            prod_d.pr = W_R * {8'd0, rgb[23:16]};
            prod_d.pg = W_G * {8'd0, rgb[15:8]};
            prod_d.pb = W_B * {8'd0, rgb[7:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
        end else begin
            prod_q <= prod_d;
        end
    end

endmodule

// File: rtl/rgb2gray_stage.sv
// rtl/rgb2gray_stage.sv - streams the RGB frame buffer through a 2-stage luma pipeline into the gray buffer
module rgb2gray_stage
    import canny_pkg::*;
#(
    parameter int FRAME_NPIX = NPIX
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    rgb2gray_stage_if.master fb,
    output logic             busy,
    output logic             done
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_NPIX - 1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          v1_q, v1_d;
    logic          run;
    luma_prod_t    prod_q;

    assign run = (state_q == ST_RUN);

    rgb2gray_mul u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (run),
        .rgb    (fb.src_rd),
        .prod_q (prod_q)
    );

    // Counter parks at the last address through DRAIN and is cleared on the way into DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        addr_d = run ? cnt_q : addr_q;
        v1_d   = run;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            v1_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            v1_q    <= v1_d;
        end
    end

    assign fb.src_addr = cnt_q;
    assign fb.dst_we   = v1_q;
    assign fb.dst_addr = addr_q;
    assign fb.dst_wd   = luma_round(prod_q);
    assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_rgb2gray_stage.sv
// tb/tb_rgb2gray_stage.sv - randomized frame conversion bench with behavioural frame-buffer and timing model
module tb_rgb2gray_stage;
    import canny_pkg::*;

    localparam int SN = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic start_big = 1'b0;
    logic busy, done, busy_b, done_b;

    always #5 clk = ~clk;

    rgb2gray_stage_if fb ();
    rgb2gray_stage_if fbb ();

    rgb2gray_stage #(.FRAME_NPIX(SN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .fb(fb), .busy(busy), .done(done)
    );
    rgb2gray_stage dut_big (
        .clk(clk), .rst_n(rst_n), .start(start_big), .fb(fbb), .busy(busy_b), .done(done_b)
    );

    int total = 0;
    int bad = 0;

    logic [23:0] src_mem [SN];
    logic [7:0]  dst_mem [SN];
    int          wr_cnt  [SN];
    int          nwr = 0;
    int          ndone = 0;
    logic [23:0] wlog [$];

    logic [23:0] big_src [NPIX];
    int          big_wr  [NPIX];
    int          big_nwr = 0;
    int          big_bad = 0;
    int          big_peak = 0;

    assign fb.src_rd  = (fb.src_addr < 16'(SN)) ? src_mem[fb.src_addr[3:0]] : 24'h0;
    assign fbb.src_rd = big_src[fbb.src_addr];

    function automatic logic [7:0] gray(input logic [23:0] p);
        int s;
        s = 77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]) + 128;
        return 8'(s / 256);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Frame-position model: k=1 is the first cycle after the accepted start, k=SN+2 is the done cycle.
    int k = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           k <= 0;
        else if (k == 0)      k <= start ? 1 : 0;
        else if (k == SN + 2) k <= 0;
        else                  k <= k + 1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", busy, (k >= 1 && k <= SN + 1));
            check("done", done, (k == SN + 2));
            check("dst_we", fb.dst_we, (k >= 2 && k <= SN + 1));
            if (k >= 2 && k <= SN + 1) begin
                check("dst_addr", fb.dst_addr, k - 2);
                check("dst_wd", fb.dst_wd, gray(src_mem[k - 2]));
            end
            if (k >= 1 && k <= SN)
                check("src_addr_run", fb.src_addr, k - 1);
            else if (k == 0 || k == SN + 2)
                check("src_addr_idle", fb.src_addr, 0);
        end
    end

    always @(posedge clk) begin
        if (fb.dst_we) begin
            dst_mem[fb.dst_addr[3:0]] <= fb.dst_wd;
            wr_cnt[fb.dst_addr[3:0]]  <= wr_cnt[fb.dst_addr[3:0]] + 1;
            nwr <= nwr + 1;
            wlog.push_back({fb.dst_addr, fb.dst_wd});
        end
        if (done) ndone <= ndone + 1;
    end

    always @(posedge clk) begin
        if (fbb.dst_we) begin
            big_wr[fbb.dst_addr] <= big_wr[fbb.dst_addr] + 1;
            big_nwr <= big_nwr + 1;
            if (fbb.dst_wd != gray(big_src[fbb.dst_addr])) big_bad <= big_bad + 1;
        end
        if (int'(fbb.src_addr) > big_peak) big_peak <= int'(fbb.src_addr);
    end

    task automatic randomize_src();
        for (int i = 0; i < SN; i++) src_mem[i] = 24'($urandom);
    endtask

    task automatic run_frame(input int e1, input int e2, input int e3, input int ncyc);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            start = (c == e1 || c == e2 || c == e3);
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    int base_wr, base_done, base_log, mism, found;
    int snap [SN];

    initial begin
        randomize_src();
        for (int i = 0; i < NPIX; i++) big_src[i] = 24'($urandom);
        for (int i = 0; i < SN; i++) wr_cnt[i] = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_dst_we", fb.dst_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_src_addr", fb.src_addr, 0);
        check("rst_dst_addr", fb.dst_addr, 0);
        check("rst_dst_wd", fb.dst_wd, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Known pixel values plus nominal timing
        src_mem[0] = 24'hFFFFFF; src_mem[1] = 24'h000000; src_mem[2] = 24'hFF0000;
        src_mem[3] = 24'h00FF00; src_mem[4] = 24'h0000FF; src_mem[5] = 24'h808080;
        base_wr = nwr; base_done = ndone;
        for (int i = 0; i < SN; i++) snap[i] = wr_cnt[i];
        run_frame(0, 0, 0, SN + 3);
        check("px_ffffff", dst_mem[0], 255);
        check("px_000000", dst_mem[1], 0);
        check("px_ff0000", dst_mem[2], 77);
        check("px_00ff00", dst_mem[3], 149);
        check("px_0000ff", dst_mem[4], 29);
        check("px_808080", dst_mem[5], 128);
        check("frame1_writes", nwr - base_wr, 16);
        check("frame1_done_pulses", ndone - base_done, 1);
        for (int i = 0; i < SN; i++) check("frame1_once", wr_cnt[i] - snap[i], 1);

        // Start pulses while busy and in DONE are ignored
        randomize_src();
        base_wr = nwr; base_done = ndone;
        run_frame(5, 17, 18, SN + 3);
        check("busy_start_writes", nwr - base_wr, 16);
        check("busy_start_done", ndone - base_done, 1);
        check("busy_start_idle_busy", busy, 0);
        check("busy_start_idle_done", done, 0);

        // Back-to-back frames
        randomize_src();
        base_wr = nwr; base_done = ndone; base_log = wlog.size();
        run_frame(19, 0, 0, 2 * SN + 5);
        check("b2b_writes", nwr - base_wr, 32);
        check("b2b_done", ndone - base_done, 2);
        mism = 0;
        for (int i = 0; i < SN; i++)
            if (wlog[base_log + i] != wlog[base_log + SN + i]) mism++;
        check("b2b_identical", mism, 0);

        // Reset at pixel 7, then restart from address 0
        randomize_src();
        base_wr = nwr;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 40 && found == 0; c++) begin
            if (fb.dst_we && fb.dst_addr == 16'd7) found = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("reach_pixel7", found, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_dst_we", fb.dst_we, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        check("abandon_writes", nwr - base_wr, 7);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < SN; i++) snap[i] = wr_cnt[i];
        run_frame(0, 0, 0, SN + 3);
        for (int i = 0; i < SN; i++) begin
            check("restart_once", wr_cnt[i] - snap[i], 1);
            check("restart_value", dst_mem[i], gray(src_mem[i]));
        end

        // Full-size frame on the default-parameter instance
        start_big = 1'b1;
        @(posedge clk); #1;
        start_big = 1'b0;
        found = 0;
        for (int c = 0; c < NPIX + 100 && found == 0; c++) begin
            @(posedge clk); #1;
            if (done_b) found = 1;
        end
        check("big_done_seen", found, 1);
        @(posedge clk); #1;
        check("big_peak_addr", big_peak, NPIX - 1);
        check("big_writes", big_nwr, NPIX);
        mism = 0;
        for (int i = 0; i < NPIX; i++) if (big_wr[i] != 1) mism++;
        check("big_each_once", mism, 0);
        check("big_values", big_bad, 0);
        check("big_idle_busy", busy_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
